// File: rtl/snow64_lane_shift_left_seq_pkg.sv
// Shared types, lane-mask table and helpers for the sequential lane-aware left shifter.
// The optional early-out build is selected with SNOW64_LANE_SHIFT_LEFT_EARLY_OUT_EN (used in the top).
package snow64_lane_shift_left_seq_pkg;

  localparam int WIDTH__DATA_INOUT = 64;

  typedef enum logic [1:0] {
    LANE_8  = 2'd0,
    LANE_16 = 2'd1,
    LANE_32 = 2'd2,
    LANE_64 = 2'd3
  } lane_size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } lsl_state_e;

  // M(w,k): clears the low 2^k bits of every lane. Entries with k >= log2(w) are never selected.
  localparam logic [63:0] LANE_MASK [4][8] = '{
    '{64'hFEFE_FEFE_FEFE_FEFE, 64'hFCFC_FCFC_FCFC_FCFC, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0,
      64'h0, 64'h0, 64'h0, 64'h0},
    '{64'hFFFE_FFFE_FFFE_FFFE, 64'hFFFC_FFFC_FFFC_FFFC, 64'hFFF0_FFF0_FFF0_FFF0,
      64'hFF00_FF00_FF00_FF00, 64'h0, 64'h0, 64'h0, 64'h0},
    '{64'hFFFF_FFFE_FFFF_FFFE, 64'hFFFF_FFFC_FFFF_FFFC, 64'hFFFF_FFF0_FFFF_FFF0,
      64'hFFFF_FF00_FFFF_FF00, 64'hFFFF_0000_FFFF_0000, 64'h0, 64'h0, 64'h0},
    '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF0,
      64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_0000, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0}
  };

  function automatic logic [2:0] lane_log2(input lane_size_e size);
    case (size)
      LANE_8:  lane_log2 = 3'd3;
      LANE_16: lane_log2 = 3'd4;
      LANE_32: lane_log2 = 3'd5;
      default: lane_log2 = 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/snow64_lsl_lane_stage.sv
// One log2 stage of the lane-aware left shift: optionally shift by 2^k, then
// mask so no bit crosses into the next lane.
module snow64_lsl_lane_stage
  import snow64_lane_shift_left_seq_pkg::*;
(
  input  logic [63:0] in_data,
  input  logic [2:0]  in_stage,
  input  lane_size_e  in_lane_size,
  input  logic        in_en,
  output logic [63:0] out_data
);

  logic [5:0] shamt;

  // NOTE: every signal written in always_comb gets a value on every path first, so no latch is inferred.
  always_comb begin
    shamt    = 6'd1 << in_stage;
    out_data = in_data;
    if (in_en) begin
      out_data = (in_data << shamt) & LANE_MASK[in_lane_size][in_stage];
    end
  end

endmodule

// File: rtl/snow64_lane_shift_left_seq.sv
// Multi-cycle lane-aware logical shift left, one log2 stage per clock.
// Define SNOW64_LANE_SHIFT_LEFT_EARLY_OUT_EN to finish once no higher amount bits remain.
module snow64_lane_shift_left_seq
  import snow64_lane_shift_left_seq_pkg::*;
#(
  parameter int WIDTH__DATA_INOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH__DATA_INOUT-1:0] in_to_shift,
  input  logic [WIDTH__DATA_INOUT-1:0] in_amount,
  input  logic [1:0]                   in_lane_size,
  output logic                         out_ready,
  output logic                         out_valid,
  output logic [WIDTH__DATA_INOUT-1:0] out_data
);

  lsl_state_e                   state_q, state_d;
  logic [WIDTH__DATA_INOUT-1:0] data_q, data_d;
  logic [5:0]                   amount_q, amount_d;
  lane_size_e                   lane_q, lane_d;
  logic [2:0]                   k_q, k_d;
  logic [WIDTH__DATA_INOUT-1:0] out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;

  lane_size_e                   in_lane;
  logic [2:0]                   in_log2;
  logic                         oversize;
  logic                         accept;
  logic                         last_stage;
  logic                         early_done;
  logic [WIDTH__DATA_INOUT-1:0] stage_out;

  assign in_lane   = lane_size_e'(in_lane_size);
  assign in_log2   = lane_log2(in_lane);
  assign oversize  = |(in_amount >> in_log2);
  assign out_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = in_valid && out_ready;
  assign last_stage = (k_q == lane_log2(lane_q) - 3'd1);

`ifdef SNOW64_LANE_SHIFT_LEFT_EARLY_OUT_EN
  // In-range amounts have no bits at or above L, so checking the whole field suffices.
  assign early_done = ((amount_q >> (k_q + 3'd1)) == 6'd0);
`else
  assign early_done = 1'b0;
`endif

  snow64_lsl_lane_stage u_stage (
    .in_data      (data_q),
    .in_stage     (k_q),
    .in_lane_size (lane_q),
    .in_en        (amount_q[k_q]),
    .out_data     (stage_out)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    amount_d    = amount_q;
    lane_d      = lane_q;
    k_d         = k_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        data_d = stage_out;
        k_d    = k_q + 3'd1;
        if (last_stage || early_done) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_data_d  = stage_out;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (oversize) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            out_data_d  = '0;
          end else begin
            state_d  = ST_SHIFT;
            data_d   = in_to_shift;
            amount_d = in_amount[5:0];
            lane_d   = in_lane;
            k_d      = 3'd0;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset here is synchronous and wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      amount_q    <= '0;
      lane_q      <= LANE_8;
      k_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      amount_q    <= amount_d;
      lane_q      <= lane_d;
      k_q         <= k_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_snow64_lane_shift_left_seq.sv
// Self-checking bench for snow64_lane_shift_left_seq against a per-lane arithmetic model.
// Latency expectations follow SNOW64_LANE_SHIFT_LEFT_EARLY_OUT_EN when it is defined.
module tb_snow64_lane_shift_left_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_to_shift;
  logic [63:0] in_amount;
  logic [1:0]  in_lane_size;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_data;

  int n_compared   = 0;
  int n_mismatched = 0;

  snow64_lane_shift_left_seq dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_to_shift  (in_to_shift),
    .in_amount    (in_amount),
    .in_lane_size (in_lane_size),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lane_w(input logic [1:0] ls);
    return 8 << ls;
  endfunction

  // Each lane is an independent w-bit integer shifted left; amounts >= w give 0.
  function automatic logic [63:0] ref_lsl(input logic [63:0] word, input logic [63:0] amt,
                                          input logic [1:0] ls);
    int w = lane_w(ls);
    logic [63:0] lmask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    logic [63:0] res = '0;
    if (amt >= 64'(w)) return '0;
    for (int i = 0; i < 64 / w; i++) begin
      logic [63:0] lane_val = (word >> (i * w)) & lmask;
      res |= ((lane_val << amt) & lmask) << (i * w);
    end
    return res;
  endfunction

  // Edges after the accept edge until out_valid is visible; oversize lands in DONE on the accept edge.
  function automatic int ref_latency(input logic [63:0] amt, input logic [1:0] ls);
    int w = lane_w(ls);
    int l = 3 + int'(ls);
    if (amt >= 64'(w)) return 0;
`ifdef SNOW64_LANE_SHIFT_LEFT_EARLY_OUT_EN
    begin
      int h = 0;
      for (int i = 0; i < l; i++) if (amt[i]) h = i + 1;
      return (h == 0) ? 1 : h;
    end
`else
    return l;
`endif
  endfunction

  task automatic run_op(input logic [63:0] word, input logic [63:0] amt, input logic [1:0] ls,
                        input string tag);
    logic [63:0] exp_data = ref_lsl(word, amt, ls);
    int exp_lat = ref_latency(amt, ls);
    int lat = 0;
    int budget = 0;
    while (!out_ready && budget < 20) begin @(posedge clk); #1; budget++; end
    n_compared++;
    if (out_ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL %s ready_wait: out_ready=%b required 1", tag, out_ready);
    end
    in_valid = 1'b1; in_to_shift = word; in_amount = amt; in_lane_size = ls;
    @(posedge clk); #1;
    // Scramble inputs mid-operation; the block must ignore them.
    in_valid = 1'b0;
    in_to_shift = {$urandom, $urandom}; in_amount = {$urandom, $urandom};
    in_lane_size = 2'($urandom);
    while (!out_valid && lat < 12) begin @(posedge clk); #1; lat++; end
    n_compared++;
    if (out_valid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL %s valid_timeout: out_valid=%b required 1", tag, out_valid);
    end
    n_compared++;
    if (lat !== exp_lat) begin
      n_mismatched++;
      $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
    end
    n_compared++;
    if (out_data !== exp_data) begin
      n_mismatched++;
      $display("FAIL %s data: got %h required %h", tag, out_data, exp_data);
    end
    @(posedge clk); #1;
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL %s pulse: out_valid=%b required 0", tag, out_valid);
    end
    n_compared++;
    if (out_data !== exp_data) begin
      n_mismatched++;
      $display("FAIL %s hold: got %h required %h", tag, out_data, exp_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    in_to_shift = 64'h1; in_amount = 64'd1; in_lane_size = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++; $display("FAIL reset_valid: got %b required 0", out_valid);
    end
    n_compared++;
    if (out_data !== 64'h0) begin
      n_mismatched++; $display("FAIL reset_data: got %h required 0", out_data);
    end
    n_compared++;
    if (out_ready !== 1'b1) begin
      n_mismatched++; $display("FAIL reset_ready: got %b required 1", out_ready);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(64'h8040_2010_0804_0201, 64'd1, 2'd0, "lane8_amt1");
    run_op(64'h1, 64'd63, 2'd3, "lane64_amt63");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 2'd1, "lane16_oversize");
    run_op(64'hDEAD_BEEF_1234_5678, 64'h1_0000_0004, 2'd2, "lane32_oversize_hi");
    run_op(64'h0000_0001_8000_0000, 64'd4, 2'd2, "lane32_cross");
    run_op(64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 2'd1, "lane16_amt0");
    run_op(64'h0123_4567_89AB_CDEF, 64'd1, 2'd3, "lane64_amt1");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  ls = 2'($urandom_range(0, 3));
      int          w = lane_w(ls);
      int          r = $urandom_range(0, 9);
      logic [63:0] amt;
      if (r < 7)       amt = 64'($urandom_range(0, w - 1));
      else if (r == 7) amt = 64'(w);
      else if (r == 8) amt = 64'd1 << $urandom_range(32, 63);
      else             amt = {$urandom, $urandom};
      run_op({$urandom, $urandom}, amt, ls, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2'd3, "abort_prep");
    in_valid = 1'b1; in_to_shift = 64'h1357_9BDF_0246_8ACE; in_amount = 64'd31; in_lane_size = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      n_compared++;
      if (out_valid !== 1'b0) begin
        n_mismatched++; $display("FAIL abort_midop_valid: got %b required 0", out_valid);
      end
    end
    rst = 1'b1; in_valid = 1'b1; in_amount = 64'd1; in_lane_size = 2'd3;
    @(posedge clk); #1;
    n_compared++;
    if (out_valid !== 1'b0) begin
      n_mismatched++; $display("FAIL abort_valid: got %b required 0", out_valid);
    end
    n_compared++;
    if (out_data !== 64'h0) begin
      n_mismatched++; $display("FAIL abort_data: got %h required 0", out_data);
    end
    n_compared++;
    if (out_ready !== 1'b1) begin
      n_mismatched++; $display("FAIL abort_ready: got %b required 1", out_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    n_compared++;
    if (pulses !== 0) begin
      n_mismatched++; $display("FAIL abort_no_pulse: got %0d pulses required 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] words [3];
    logic [63:0] amts [3];
    logic [63:0] exp_q [$];
    int idx = 0, nres = 0, cyc = 0, last = 0;
    for (int i = 0; i < 3; i++) begin
      words[i] = {$urandom, $urandom};
      amts[i]  = 64'($urandom_range(4, 7));
    end
    in_valid = 1'b1; in_to_shift = words[0]; in_amount = amts[0]; in_lane_size = 2'd0;
    while (nres < 3 && cyc < 40) begin
      logic rdy_before = out_ready;
      logic ov_before  = out_valid;
      @(posedge clk); #1;
      cyc++;
      if (in_valid && rdy_before) begin
        exp_q.push_back(ref_lsl(words[idx], amts[idx], 2'd0));
        if (idx > 0) begin
          n_compared++;
          if (ov_before !== 1'b1) begin
            n_mismatched++;
            $display("FAIL b2b_accept_in_done%0d: out_valid before accept %b required 1", idx, ov_before);
          end
        end
        idx++;
        if (idx < 3) begin
          in_to_shift = words[idx]; in_amount = amts[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid === 1'b1) begin
        logic [63:0] exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        n_compared++;
        if (out_data !== exp_data) begin
          n_mismatched++;
          $display("FAIL b2b_data%0d: got %h required %h", nres, out_data, exp_data);
        end
        if (nres > 0) begin
          n_compared++;
          if (cyc - last !== 4) begin
            n_mismatched++;
            $display("FAIL b2b_period%0d: got %0d cycles required 4", nres, cyc - last);
          end
        end
        last = cyc;
        nres++;
      end
    end
    in_valid = 1'b0;
    n_compared++;
    if (nres !== 3) begin
      n_mismatched++; $display("FAIL b2b_count: got %0d results required 3", nres);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    in_to_shift = '0; in_amount = '0; in_lane_size = '0;
    #2;
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
